// File: rtl/i2c_controller_multibyte_if.sv
// Host/datapath bundle for the multi-byte I2C controller.
// master = controller side, slave = host + shift-register datapath side.
interface i2c_controller_multibyte_if #(
   parameter int BCW = 3
);
   logic           Go;
   logic           ClockI2C;
   logic           RW;
   logic [BCW-1:0] NumBytes;
   logic           SDAIn;
   logic           WriteLoad;
   logic           ReadorWrite;
   logic           ShiftorHold;
   logic           Select;
   logic           BaudEnable;
   logic           StartStopAck;
   logic           ByteDone;
   logic           Busy;
   logic           AckError;

   modport master (
      input  Go, ClockI2C, RW, NumBytes, SDAIn,
      output WriteLoad, ReadorWrite, ShiftorHold,
      output Select, BaudEnable, StartStopAck,
      output ByteDone, Busy, AckError
   );

   modport slave (
      output Go, ClockI2C, RW, NumBytes, SDAIn,
      input  WriteLoad, ReadorWrite, ShiftorHold,
      input  Select, BaudEnable, StartStopAck,
      input  ByteDone, Busy, AckError
   );
endinterface

// File: rtl/i2c_controller_multibyte.sv
// I2C master control FSM: multi-byte read/write bursts with
// slave-ACK abort and master ACK/NACK, paced by ClockI2C edges.
module i2c_controller_multibyte #(
   parameter int DATA_WIDTH = 8,
   parameter int BCW        = 3,
   parameter int DIVIDER    = 16
) (
   input logic clock,
   input logic Reset,
   i2c_controller_multibyte_if.master bus
);

   localparam int DCW = $clog2(DATA_WIDTH + 1);
   localparam int TCW = $clog2(DIVIDER + 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      LOAD     = 3'd2,
      TRANSMIT = 3'd3,
      ACK      = 3'd4,
      STOP     = 3'd5,
      WAIT     = 3'd6
   } state_t;

   state_t         state_q, state_d;
   logic [DCW-1:0] dc_q, dc_d;
   logic [BCW-1:0] bc_q, bc_d;
   logic [TCW-1:0] tc_q, tc_d;
   logic           rw_q, rw_d;
   logic           ae_q, ae_d;
   logic           ssa_q, ssa_d;
   logic           scl1_q, scl2_q;

   logic pos, neg;
   logic wl, rdwr, sh, sel, baud, ssa_o, bdone;

   assign pos = scl1_q & ~scl2_q;
   assign neg = ~scl1_q & scl2_q;

   always_ff @(posedge clock) begin
      if (Reset) begin
         state_q <= IDLE;
         dc_q    <= '0;
         bc_q    <= '0;
         tc_q    <= '0;
         rw_q    <= 1'b0;
         ae_q    <= 1'b0;
         ssa_q   <= 1'b1;
         scl1_q  <= 1'b0;
         scl2_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dc_q    <= dc_d;
         bc_q    <= bc_d;
         tc_q    <= tc_d;
         rw_q    <= rw_d;
         ae_q    <= ae_d;
         ssa_q   <= ssa_d;
         scl1_q  <= bus.ClockI2C;
         scl2_q  <= scl1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      dc_d    = dc_q;
      bc_d    = bc_q;
      tc_d    = '0;
      rw_d    = rw_q;
      ae_d    = ae_q;
      ssa_d   = 1'b1;
      wl      = 1'b0;
      rdwr    = 1'b0;
      sh      = 1'b0;
      sel     = 1'b1;
      baud    = 1'b1;
      ssa_o   = 1'b1;
      bdone   = 1'b0;
      unique case (state_q)
         IDLE: begin
            baud = 1'b0;
            if (bus.Go) begin
               rw_d    = bus.RW;
               bc_d    = (bus.NumBytes == '0) ? BCW'(1)
                                              : bus.NumBytes;
               ae_d    = 1'b0;
               state_d = START;
            end
         end
         START: begin
            // SDA falls while SCL is high, then wait for SCL low
            ssa_d = ssa_q;
            ssa_o = ssa_q;
            if (pos) begin
               ssa_d = 1'b0;
            end else if (neg && !ssa_q) begin
               state_d = LOAD;
            end
         end
         LOAD: begin
            ssa_o   = 1'b0;
            wl      = ~rw_q;
            dc_d    = DCW'(DATA_WIDTH);
            state_d = TRANSMIT;
         end
         TRANSMIT: begin
            rdwr  = rw_q;
            sel   = rw_q;
            ssa_o = rw_q;
            sh    = rw_q ? pos : neg;
            if (neg) begin
               dc_d = dc_q - DCW'(1);
               if (dc_q == DCW'(1)) begin
                  state_d = ACK;
               end
            end
         end
         ACK: begin
            // reads: ACK every byte but the last, which is NACKed
            rdwr  = ~rw_q;
            ssa_o = rw_q ? (bc_q <= BCW'(1)) : 1'b1;
            if (pos && !rw_q && bus.SDAIn) begin
               ae_d = 1'b1;
            end
            if (neg) begin
               bdone = 1'b1;
               bc_d  = bc_q - BCW'(1);
               if (ae_q || bc_q == BCW'(1)) begin
                  state_d = STOP;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         STOP: begin
            ssa_o = 1'b0;
            if (pos) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            baud = 1'b0;
            tc_d = tc_q + TCW'(1);
            if (tc_q == TCW'(DIVIDER - 1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.WriteLoad    = wl;
   assign bus.ReadorWrite  = rdwr;
   assign bus.ShiftorHold  = sh;
   assign bus.Select       = sel;
   assign bus.BaudEnable   = baud;
   assign bus.StartStopAck = ssa_o;
   assign bus.ByteDone     = bdone;
   assign bus.Busy         = (state_q != IDLE);
   assign bus.AckError     = ae_q;

endmodule

// File: tb/tb_i2c_controller_multibyte.sv
// Directed bench for i2c_controller_multibyte: write/read bursts,
// ACK abort, NumBytes=0, Go while busy and mid-burst reset.
module tb_i2c_controller_multibyte;

   localparam int BCW = 3;
   localparam int DIV = 3;

   logic clock = 1'b0;
   logic Reset = 1'b1;
   logic scl   = 1'b0;
   int   scl_cnt = 0;

   int n_cmp = 0;
   int n_bad = 0;

   int   wl = 0, sh = 0, sh_hi = 0, bd = 0, stops = 0, wt = 0;
   logic prev_be = 1'b0;
   logic ack_lv [64];
   int   wl0, sh0, shh0, bd0, st0, wt0;

   i2c_controller_multibyte_if #(.BCW(BCW)) bus ();

   i2c_controller_multibyte #(
      .DATA_WIDTH(8),
      .BCW       (BCW),
      .DIVIDER   (DIV)
   ) dut (
      .clock(clock),
      .Reset(Reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (scl_cnt == 2) begin
         scl_cnt = 0;
         scl = ~scl;
      end else begin
         scl_cnt++;
      end
   end

   assign bus.ClockI2C = scl;

   always @(negedge clock) begin
      if (bus.WriteLoad) wl++;
      if (bus.ShiftorHold) begin
         sh++;
         if (scl) sh_hi++;
      end
      if (bus.ByteDone) begin
         ack_lv[bd % 64] = bus.StartStopAck;
         bd++;
      end
      if (bus.Busy && !bus.BaudEnable) begin
         wt++;
         if (prev_be) stops++;
      end
      prev_be = bus.BaudEnable;
   end

   task automatic chk(input string tag, input int got,
                      input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic go_pulse(input logic rw, input logic [2:0] nb,
                           input logic sda);
      @(negedge clock);
      wl0 = wl; sh0 = sh; shh0 = sh_hi;
      bd0 = bd; st0 = stops; wt0 = wt;
      bus.RW = rw;
      bus.NumBytes = nb;
      bus.SDAIn = sda;
      bus.Go = 1'b1;
      @(negedge clock);
      bus.Go = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (bus.Busy && k < 3000) begin
         @(negedge clock);
         k++;
      end
      chk({tag, "_idle"}, int'(bus.Busy), 0);
      @(negedge clock);
   endtask

   task automatic wait_wl(input string tag, input int n);
      int k = 0;
      while (wl - wl0 < n && k < 2000) begin
         @(negedge clock);
         k++;
      end
      chk({tag, "_wl_wait"}, int'(wl - wl0 >= n), 1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_wl"},   int'(bus.WriteLoad), 0);
      chk({tag, "_rdwr"}, int'(bus.ReadorWrite), 0);
      chk({tag, "_sh"},   int'(bus.ShiftorHold), 0);
      chk({tag, "_sel"},  int'(bus.Select), 1);
      chk({tag, "_baud"}, int'(bus.BaudEnable), 0);
      chk({tag, "_ssa"},  int'(bus.StartStopAck), 1);
      chk({tag, "_bd"},   int'(bus.ByteDone), 0);
      chk({tag, "_busy"}, int'(bus.Busy), 0);
      chk({tag, "_ae"},   int'(bus.AckError), 0);
   endtask

   initial begin
      bus.Go = 1'b0;
      bus.RW = 1'b0;
      bus.NumBytes = '0;
      bus.SDAIn = 1'b0;
      @(negedge clock);
      chk_reset_outs("rst");
      Reset = 1'b0;
      repeat (4) @(negedge clock);

      go_pulse(1'b0, 3'd1, 1'b0);
      chk("w1_busy", int'(bus.Busy), 1);
      wait_idle("w1");
      chk("w1_wl", wl - wl0, 1);
      chk("w1_sh", sh - sh0, 8);
      chk("w1_sh_hi", sh_hi - shh0, 0);
      chk("w1_bd", bd - bd0, 1);
      chk("w1_stop", stops - st0, 1);
      chk("w1_wait", wt - wt0, DIV);
      chk("w1_ae", int'(bus.AckError), 0);

      go_pulse(1'b0, 3'd3, 1'b0);
      wait_idle("w3");
      chk("w3_wl", wl - wl0, 3);
      chk("w3_sh", sh - sh0, 24);
      chk("w3_bd", bd - bd0, 3);
      chk("w3_stop", stops - st0, 1);
      chk("w3_wait", wt - wt0, DIV);
      chk("w3_ae", int'(bus.AckError), 0);

      go_pulse(1'b0, 3'd3, 1'b1);
      wait_idle("nak");
      chk("nak_ae", int'(bus.AckError), 1);
      chk("nak_bd", bd - bd0, 1);
      chk("nak_wl", wl - wl0, 1);
      chk("nak_sh", sh - sh0, 8);
      chk("nak_stop", stops - st0, 1);

      go_pulse(1'b1, 3'd2, 1'b0);
      chk("rd_ae_clr", int'(bus.AckError), 0);
      wait_idle("rd");
      chk("rd_sh", sh - sh0, 16);
      chk("rd_sh_hi", sh_hi - shh0, 16);
      chk("rd_wl", wl - wl0, 0);
      chk("rd_bd", bd - bd0, 2);
      chk("rd_ack1", int'(ack_lv[bd0 % 64]), 0);
      chk("rd_ack2", int'(ack_lv[(bd0 + 1) % 64]), 1);
      chk("rd_stop", stops - st0, 1);

      go_pulse(1'b0, 3'd0, 1'b0);
      wait_idle("n0");
      chk("n0_wl", wl - wl0, 1);
      chk("n0_bd", bd - bd0, 1);
      chk("n0_sh", sh - sh0, 8);

      go_pulse(1'b0, 3'd2, 1'b0);
      wait_wl("gb", 1);
      repeat (12) @(negedge clock);
      bus.RW = 1'b1;
      bus.NumBytes = 3'd5;
      bus.Go = 1'b1;
      @(negedge clock);
      bus.Go = 1'b0;
      wait_idle("gb");
      chk("gb_wl", wl - wl0, 2);
      chk("gb_bd", bd - bd0, 2);
      chk("gb_sh_hi", sh_hi - shh0, 0);
      chk("gb_stop", stops - st0, 1);

      go_pulse(1'b0, 3'd3, 1'b0);
      wait_wl("mr", 2);
      repeat (12) @(negedge clock);
      chk("mr_busy", int'(bus.Busy), 1);
      Reset = 1'b1;
      @(negedge clock);
      chk_reset_outs("mr");
      Reset = 1'b0;
      wl0 = wl; st0 = stops; bd0 = bd;
      repeat (40) @(negedge clock);
      chk("mr_idle", int'(bus.Busy), 0);
      chk("mr_wl", wl - wl0, 0);
      chk("mr_bd", bd - bd0, 0);
      chk("mr_stop", stops - st0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
